// File: rtl/pair_triple_generator_pkg.sv
// pair_triple_pkg: shared definitions for the pair/triple stimulus generator.
//   - MODE_* : 2-bit pattern-class selectors (LOW, HIGH, ALL, PAIR)
//   - state_t: generator FSM states (ST_IDLE, ST_EMIT)
//   - popcount3 / is_member / first_code / last_code: class membership helpers
package pair_triple_pkg;

  localparam logic [1:0] MODE_LOW  = 2'd0;  // popcount <= 1
  localparam logic [1:0] MODE_HIGH = 2'd1;  // popcount >= 2
  localparam logic [1:0] MODE_ALL  = 2'd2;  // every code
  localparam logic [1:0] MODE_PAIR = 2'd3;  // popcount == 2

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic logic [1:0] popcount3(input logic [2:0] code);
    return {1'b0, code[0]} + {1'b0, code[1]} + {1'b0, code[2]};
  endfunction

  function automatic logic is_member(input logic [1:0] mode, input logic [2:0] code);
    logic [1:0] p;
    p = popcount3(code);
    case (mode)
      MODE_LOW:  return (p <= 2'd1);
      MODE_HIGH: return (p >= 2'd2);
      MODE_PAIR: return (p == 2'd2);
      default:   return 1'b1;
    endcase
  endfunction

  // Lowest member of each class.
  function automatic logic [2:0] first_code(input logic [1:0] mode);
    case (mode)
      MODE_HIGH, MODE_PAIR: return 3'd3;
      default:              return 3'd0;
    endcase
  endfunction

  // Highest member of each class; the walk ends here.
  function automatic logic [2:0] last_code(input logic [1:0] mode);
    case (mode)
      MODE_LOW:  return 3'd4;
      MODE_PAIR: return 3'd6;
      default:   return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/pair_triple_generator_if.sv
// pair_triple_generator_if: request and pattern-stream signals of the generator.
//   Request : req_val, req_rdy, req_mode
//   Stream  : resp_val, resp_rdy, in0/in1/in2, exp_out, resp_last
// Handshake rule (both channels): a transfer happens on a rising clock edge where
// valid and ready are both high; a source holds valid and its payload stable until
// that edge, and ready may change freely. Flush and reset are the only ways valid
// is withdrawn without a transfer.
// Modports: master = generator side, slave = harness/consumer side.
interface pair_triple_generator_if;
  logic       req_val;
  logic       req_rdy;
  logic [1:0] req_mode;
  logic       resp_val;
  logic       resp_rdy;
  logic       in0;
  logic       in1;
  logic       in2;
  logic       exp_out;
  logic       resp_last;

  modport master (
    input  req_val, req_mode, resp_rdy,
    output req_rdy, resp_val, in0, in1, in2, exp_out, resp_last
  );

  modport slave (
    output req_val, req_mode, resp_rdy,
    input  req_rdy, resp_val, in0, in1, in2, exp_out, resp_last
  );
endinterface

// File: rtl/pair_triple_generator_next_code.sv
// pair_triple_next_code: combinational successor logic for the class walk.
//   mode    in  2  pattern class
//   code    in  3  current code (assumed to be a member of the class)
//   nxt     out 3  next higher member; wraps to the first member after the last
//   is_last out 1  code is the highest member of the class
module pair_triple_next_code
  import pair_triple_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] code,
  output logic [2:0] nxt,
  output logic       is_last
);

  // Scan candidates from the top down so the lowest qualifying code wins.
  // With no qualifying code above, the walk restarts at the first member.
  always_comb begin
    nxt = first_code(mode);
    for (int i = 7; i >= 1; i--) begin
      if ((3'(i) > code) && is_member(mode, 3'(i))) begin
        nxt = 3'(i);
      end
    end
  end

  assign is_last = (code == last_code(mode));

endmodule

// File: rtl/pair_triple_generator.sv
// pair_triple_generator: walks every member of a requested 3-bit pattern class in
// ascending order, NUM_PASSES times, emitting each pattern with its golden
// detector output NOT(majority(in0, in1, in2)).
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous abort back to IDLE (beats any handshake)
//   pif        if   master side of pair_triple_generator_if (request + stream)
//   busy       out  high whenever the FSM is not IDLE
//   state_dbg  out  current FSM state
module pair_triple_generator
  import pair_triple_pkg::*;
#(
  parameter int NUM_PASSES = 1,
  parameter int PASS_W     = $clog2(NUM_PASSES) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  pair_triple_generator_if.master  pif,
  output logic                     busy,
  output state_t                   state_dbg
);

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_t            state;
  logic [2:0]        code;
  logic [PASS_W-1:0] pass;
  logic [1:0]        mode;
  logic              req_rdy_q;
  logic              resp_val_q;

  logic [2:0]        nxt_code;
  logic              code_is_last;
  logic              resp_last;
  logic              resp_fire;

  pair_triple_next_code u_next_code (
    .mode    (mode),
    .code    (code),
    .nxt     (nxt_code),
    .is_last (code_is_last)
  );

  assign resp_last = resp_val_q && code_is_last && (pass == LAST_PASS);
  assign resp_fire = resp_val_q && pif.resp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      code       <= 3'd0;
      pass       <= '0;
      mode       <= MODE_LOW;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else if (flush) begin
      // The pattern on the bus this cycle is discarded, not consumed.
      state      <= ST_IDLE;
      code       <= 3'd0;
      pass       <= '0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pif.req_val && req_rdy_q) begin
            mode       <= pif.req_mode;
            code       <= first_code(pif.req_mode);
            pass       <= '0;
            state      <= ST_EMIT;
            req_rdy_q  <= 1'b0;
            resp_val_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (resp_fire) begin
            if (resp_last) begin
              // req_rdy only rises after this edge, so a new request always
              // sees at least one dead cycle.
              state      <= ST_IDLE;
              code       <= 3'd0;
              pass       <= '0;
              req_rdy_q  <= 1'b1;
              resp_val_q <= 1'b0;
            end else if (code_is_last) begin
              code <= nxt_code;  // wraps to the first member
              pass <= pass + PASS_W'(1);
            end else begin
              code <= nxt_code;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign pif.req_rdy   = req_rdy_q;
  assign pif.resp_val  = resp_val_q;
  assign pif.in0       = code[0];
  assign pif.in1       = code[1];
  assign pif.in2       = code[2];
  assign pif.exp_out   = (popcount3(code) <= 2'd1);
  assign pif.resp_last = resp_last;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_pair_triple_generator.sv
// Directed bench for pair_triple_generator: one instance with a single pass and
// one with two passes, sharing clock and reset.
module tb_pair_triple_generator;
  import pair_triple_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   flush1;
  logic   flush2;
  logic   busy1;
  logic   busy2;
  state_t st1;
  state_t st2;

  int n_cmp  = 0;
  int n_fail = 0;

  pair_triple_generator_if if1 ();
  pair_triple_generator_if if2 ();

  pair_triple_generator #(.NUM_PASSES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush1),
    .pif       (if1),
    .busy      (busy1),
    .state_dbg (st1)
  );

  pair_triple_generator #(.NUM_PASSES(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush2),
    .pif       (if2),
    .busy      (busy2),
    .state_dbg (st2)
  );

  // Observed stream word: {resp_val, in2, in1, in0, exp_out, resp_last}
  logic [5:0] obs1;
  logic [5:0] obs2;
  assign obs1 = {if1.resp_val, if1.in2, if1.in1, if1.in0, if1.exp_out, if1.resp_last};
  assign obs2 = {if2.resp_val, if2.in2, if2.in1, if2.in0, if2.exp_out, if2.resp_last};

  localparam logic [5:0] IDLE_WORD = 6'b0_000_1_0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks (each starts and ends just after a negedge) ----
  task automatic test_reset();
    #12;
    n_cmp++;
    if (obs1 !== IDLE_WORD) begin
      n_fail++; $display("FAIL reset_outputs1 got %b want %b", obs1, IDLE_WORD);
    end
    n_cmp++;
    if (obs2 !== IDLE_WORD) begin
      n_fail++; $display("FAIL reset_outputs2 got %b want %b", obs2, IDLE_WORD);
    end
    n_cmp++;
    if ({if1.req_rdy, busy1, st1} !== {1'b1, 1'b0, ST_IDLE}) begin
      n_fail++; $display("FAIL reset_ctrl1 got rdy=%b busy=%b st=%0d", if1.req_rdy, busy1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({obs1, if1.req_rdy, busy1} !== {IDLE_WORD, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_idle got %b rdy=%b busy=%b", obs1, if1.req_rdy, busy1);
    end
  endtask

  task automatic test_all();
    logic [7:0] exp_tab;
    logic [5:0] exp_w;
    exp_tab = 8'b0001_0111;  // exp_out for codes 7..0
    if1.req_val = 1'b1; if1.req_mode = MODE_ALL; if1.resp_rdy = 1'b1;
    @(negedge clk);
    if1.req_val = 1'b0;
    n_cmp++;
    if ({if1.req_rdy, busy1} !== 2'b01) begin
      n_fail++; $display("FAIL all_ctrl_emit got rdy=%b busy=%b want 0 1", if1.req_rdy, busy1);
    end
    for (int i = 0; i < 8; i++) begin
      exp_w = {1'b1, 3'(i), exp_tab[i], (i == 7)};
      n_cmp++;
      if (obs1 !== exp_w) begin
        n_fail++; $display("FAIL all_seq[%0d] got %b want %b", i, obs1, exp_w);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({if1.resp_val, if1.req_rdy, busy1} !== 3'b010) begin
      n_fail++; $display("FAIL all_back_idle got val=%b rdy=%b busy=%b", if1.resp_val, if1.req_rdy, busy1);
    end
  endtask

  task automatic test_pair_stall();
    logic [5:0] exp_q[$];
    logic       rdy_tog;
    exp_q = '{6'b1_011_0_0, 6'b1_101_0_0, 6'b1_110_0_1};
    if1.req_val = 1'b1; if1.req_mode = MODE_PAIR; if1.resp_rdy = 1'b0;
    @(negedge clk);
    if1.req_val = 1'b0;
    rdy_tog = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      // A stalled word must reappear unchanged on the next cycle.
      n_cmp++;
      if (obs1 !== exp_q[0]) begin
        n_fail++; $display("FAIL pair_word cyc%0d got %b want %b", c, obs1, exp_q[0]);
      end
      if1.resp_rdy = rdy_tog;
      if (rdy_tog) void'(exp_q.pop_front());
      rdy_tog = ~rdy_tog;
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL pair_timeout got %0d left want 0", exp_q.size());
    end
    n_cmp++;
    if ({if1.resp_val, if1.req_rdy, busy1} !== 3'b010) begin
      n_fail++; $display("FAIL pair_back_idle got val=%b rdy=%b busy=%b", if1.resp_val, if1.req_rdy, busy1);
    end
    if1.resp_rdy = 1'b1;
  endtask

  task automatic test_two_passes();
    logic [2:0] codes[8];
    logic [5:0] exp_w;
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4};
    if2.req_val = 1'b1; if2.req_mode = MODE_LOW; if2.resp_rdy = 1'b1;
    @(negedge clk);
    if2.req_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_w = {1'b1, codes[i], 1'b1, (i == 7)};
      n_cmp++;
      if (obs2 !== exp_w) begin
        n_fail++; $display("FAIL low2_seq[%0d] got %b want %b", i, obs2, exp_w);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({if2.resp_val, if2.req_rdy, busy2} !== 3'b010) begin
      n_fail++; $display("FAIL low2_back_idle got val=%b rdy=%b busy=%b", if2.resp_val, if2.req_rdy, busy2);
    end
  endtask

  task automatic test_flush();
    logic [2:0] codes[4];
    logic [5:0] exp_w;
    codes = '{3'd3, 3'd5, 3'd6, 3'd7};
    if1.req_val = 1'b1; if1.req_mode = MODE_HIGH; if1.resp_rdy = 1'b1;
    @(negedge clk);
    if1.req_val = 1'b0;
    n_cmp++;
    if (obs1 !== 6'b1_011_0_0) begin
      n_fail++; $display("FAIL high_first got %b want %b", obs1, 6'b1_011_0_0);
    end
    @(negedge clk);
    n_cmp++;
    if (obs1 !== 6'b1_101_0_0) begin
      n_fail++; $display("FAIL high_second got %b want %b", obs1, 6'b1_101_0_0);
    end
    flush1 = 1'b1;  // together with resp_rdy=1: flush wins
    @(negedge clk);
    flush1 = 1'b0;
    n_cmp++;
    if ({obs1, if1.req_rdy, busy1} !== {IDLE_WORD, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL flush_idle got %b rdy=%b busy=%b", obs1, if1.req_rdy, busy1);
    end
    // Flush in IDLE blocks acceptance for that cycle.
    flush1 = 1'b1; if1.req_val = 1'b1; if1.req_mode = MODE_HIGH;
    @(negedge clk);
    flush1 = 1'b0;
    n_cmp++;
    if ({if1.resp_val, busy1} !== 2'b00) begin
      n_fail++; $display("FAIL flush_blocks_req got val=%b busy=%b want 0 0", if1.resp_val, busy1);
    end
    @(negedge clk);
    if1.req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w = {1'b1, codes[i], 1'b0, (i == 3)};
      n_cmp++;
      if (obs1 !== exp_w) begin
        n_fail++; $display("FAIL high_restart[%0d] got %b want %b", i, obs1, exp_w);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({if1.resp_val, if1.req_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL high_back_idle got val=%b rdy=%b", if1.resp_val, if1.req_rdy);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_tab;
    logic [5:0] exp_w;
    exp_tab = 8'b0001_0111;
    if1.req_val = 1'b1; if1.req_mode = MODE_ALL; if1.resp_rdy = 1'b1;
    @(negedge clk);
    if1.req_val = 1'b0;
    if1.req_mode = MODE_PAIR;  // must not affect the running walk
    for (int i = 0; i < 3; i++) begin
      exp_w = {1'b1, 3'(i), exp_tab[i], 1'b0};
      n_cmp++;
      if (obs1 !== exp_w) begin
        n_fail++; $display("FAIL arst_pre[%0d] got %b want %b", i, obs1, exp_w);
      end
      if (i < 2) @(negedge clk);
    end
    #2 rst_n = 1'b0;  // clock is low; next rising edge is 3 time units away
    #1;
    n_cmp++;
    if ({obs1, if1.req_rdy, busy1, st1} !== {IDLE_WORD, 1'b1, 1'b0, ST_IDLE}) begin
      n_fail++; $display("FAIL arst_immediate got %b rdy=%b busy=%b", obs1, if1.req_rdy, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if1.req_val = 1'b1; if1.req_mode = MODE_ALL;
    @(negedge clk);
    if1.req_val = 1'b0;
    if1.req_mode = MODE_LOW;  // ignored after acceptance
    for (int i = 0; i < 8; i++) begin
      exp_w = {1'b1, 3'(i), exp_tab[i], (i == 7)};
      n_cmp++;
      if (obs1 !== exp_w) begin
        n_fail++; $display("FAIL arst_after[%0d] got %b want %b", i, obs1, exp_w);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({if1.resp_val, if1.req_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL arst_back_idle got val=%b rdy=%b", if1.resp_val, if1.req_rdy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    if1.req_val = 1'b0; if1.req_mode = 2'd0; if1.resp_rdy = 1'b0;
    if2.req_val = 1'b0; if2.req_mode = 2'd0; if2.resp_rdy = 1'b0;
    test_reset();
    test_all();
    test_pair_stall();
    test_two_passes();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
